idli_sqi_deser_m: RTL and testbench
===================================

Name: idli_sqi_deser_m

Overview:
Parametrised instruction deserialiser and queue between the SQI fetch path and the decoder. It accepts instruction encodings LANE_W bits per cycle, MSB-first, and assembles them into 16b instruction words. It detects instructions followed by a 16b immediate word and pairs each such instruction with its immediate. Completed entries are buffered in a DEPTH-entry FIFO with valid/ready handshakes on both sides, so decode can stall without losing fetched data.

Parameters:
LANE_W, 4, bits accepted per beat; legal values 4, 8, 16; BEATS = 16/LANE_W beats per word.
DEPTH, 4, FIFO entries; legal range 2..8.

Ports:
i_dsr_gck  in  1  clock.
i_dsr_rst_n  in  1  reset; asynchronous, active-low.
i_dsr_flush  in  1  synchronous flush of all buffered and partial state.
i_dsr_enc  in  LANE_W  encoding beat; first beat carries word bits [15:16-LANE_W].
i_dsr_enc_vld  in  1  beat valid.
o_dsr_enc_rdy  out  1  beat accepted when vld && rdy.
o_dsr_instr  out  16  head entry instruction word.
o_dsr_imm  out  16  head entry immediate.
o_dsr_imm_vld  out  1  head entry carries an immediate.
o_dsr_vld  out  1  head entry valid.
i_dsr_rdy  in  1  consumer pops head when vld && rdy.
o_dsr_cnt  out  $clog2(DEPTH+1)  entries currently held.

Behaviour:
- Reset (async): FIFO empty, cnt=0, state ST_INSTR, beat counter 0, shift register 0. Outputs: o_dsr_vld=0, o_dsr_instr/imm/imm_vld=0, o_dsr_enc_rdy=1.
- o_dsr_enc_rdy = (cnt < DEPTH). There is no same-cycle pop-to-rdy bypass, so no combinational path exists from i_dsr_rdy to o_dsr_enc_rdy.
- Accepted beats shift into a 16b register MSB-first. The beat counter runs 0..BEATS-1 and wraps. The word completes on the beat with counter == BEATS-1.
- State machine:
  - ST_INSTR: on word completion, if enc_has_imm(word) then latch the word in the staging register and go to ST_IMM. Otherwise push {word, 16'h0, 0} and stay in ST_INSTR.
  - ST_IMM: on word completion, push {staged, word, 1} and go to ST_INSTR.
- enc_has_imm(w) = (w[2:0]==3'b111) && !(w[15:12]==4'b0000 && w[8]==0) && (w[15:12]!=4'b1011) && !(w[15:12]==4'b0101 && w[11] && w[8]). This excludes NOP, the stack/perm/inv/inc/urx group, and cmpz/putp.
- A push can occur only on an accepted beat, and beats are accepted only when cnt < DEPTH, so a push can never overflow the FIFO.
- Pop: o_dsr_vld = (cnt != 0); the head is removed on o_dsr_vld && i_dsr_rdy. When o_dsr_vld=0, the data outputs are driven 0.
- Push and pop in the same cycle: cnt unchanged, order preserved. Pop while empty is ignored.
- FIFO pointers wrap modulo DEPTH; non-power-of-two DEPTH must be handled.
- Latency: if the last beat of an entry is accepted in cycle N with the FIFO empty, o_dsr_vld=1 in cycle N+1. Sustained throughput is one beat per cycle.
- Flush (priority over everything): the next cycle shows cnt=0, ST_INSTR, beat counter 0, and staging cleared. The beat offered in the flush cycle is dropped even if rdy=1. A pop in the flush cycle is ignored.
- Reset asserted mid-word or mid-immediate returns immediately to the reset state; partial data is discarded.

Decomposition:
- idli_pkg:
  - INSTR_W=16.
  - dsr_state_t enum {ST_INSTR, ST_IMM}.
  - dsr_entry_t packed struct {instr, imm, imm_vld}.
  - enc_has_imm() function, shared with decode.
- Sub-module: idli_fifo_m, generic parametrised FIFO (WIDTH, DEPTH) exposing push/pop/cnt/head. Its clock and async active-low reset follow the same port rules.

Test Plan:
- LANE_W=4, DEPTH=2, rdy=1: beats C,2,4,1 -> one cycle after the 4th beat, o_dsr_vld=1 for one cycle, instr=0xC241, imm_vld=0.
- LANE_W=4: beats C,2,4,7,1,2,3,4 -> no vld after beat 4; after beat 8, a single entry with instr=0xC247, imm=0x1234, imm_vld=1.
- Immediate-rule corners:
  - 0x0007 -> entry pushed after 4 beats, imm_vld=0.
  - 0x0107 followed by 0xBEEF -> imm_vld=1, imm=0xBEEF.
  - 0xB8A7 -> imm_vld=0.
- DEPTH=2, i_dsr_rdy=0: send 0x1111, 0x2222, 0x3333 -> cnt=2 and enc_rdy=0 after the second word; third word's beats stall. Raise rdy -> pops in order 0x1111, 0x2222; 0x3333 is then accepted, and cnt never exceeds 2.
- Flush after two beats of 0xC247, with one entry queued -> cnt=0, vld=0. Next beats 5,0,0,1 -> entry 0x5001, imm_vld=0.
- LANE_W=8: beats C2,47,12,34 -> instr=0xC247, imm=0x1234. Also assert reset mid-entry -> all outputs return to reset values at once.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared types and helpers for the SQI instruction deserialiser.
// Also used by decode to classify immediate-carrying encodings.
package idli_pkg;

   localparam int INSTR_W = 16;

   typedef enum logic {
      ST_INSTR,
      ST_IMM
   } dsr_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [INSTR_W-1:0] imm;
      logic               imm_vld;
   } dsr_entry_t;

   // Low bits 111 mark an immediate operand, except NOP, the
   // stack/perm/inv/inc/urx group and cmpz/putp.
   function automatic logic enc_has_imm(input logic [INSTR_W-1:0] w);
      logic [3:0] op;
      op = w[15:12];
      return (w[2:0] == 3'b111)
          && !(op == 4'b0000 && !w[8])
          && (op != 4'b1011)
          && !(op == 4'b0101 && w[11] && w[8]);
   endfunction

endpackage

// File: rtl/idli_fifo_m.sv
// Generic circular FIFO with count, head view and sync flush.
// Pointers wrap modulo DEPTH so any depth >= 2 is supported.
module idli_fifo_m #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       i_gck,
   input  logic                       i_rst_n,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head,
   output logic [$clog2(DEPTH+1)-1:0] o_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CW-1:0]    r_cnt;
   logic             w_push;
   logic             w_pop;

   function automatic logic [PW-1:0] f_nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_pop  = i_pop && (r_cnt != '0);
   assign w_push = i_push && (r_cnt < CW'(DEPTH));
   assign o_head = r_mem[r_rd];
   assign o_cnt  = r_cnt;

   // Pointer and occupancy bookkeeping; flush empties the queue.
   always_ff @(posedge i_gck or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= f_nxt(r_wr);
         if (w_pop)  r_rd <= f_nxt(r_rd);
         if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
         else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
      end
   end

   // Storage needs no reset: reads are qualified by the count.
   always_ff @(posedge i_gck) begin
      if (w_push && !i_flush) r_mem[r_wr] <= i_data;
   end

endmodule

// File: rtl/idli_sqi_deser_m.sv
// SQI instruction deserialiser: beats -> 16b words -> paired
// {instr, imm} entries queued for the decoder.
module idli_sqi_deser_m
   import idli_pkg::*;
#(
   parameter int LANE_W = 4,
   parameter int DEPTH  = 4
) (
   input  logic                       i_dsr_gck,
   input  logic                       i_dsr_rst_n,
   input  logic                       i_dsr_flush,
   input  logic [LANE_W-1:0]          i_dsr_enc,
   input  logic                       i_dsr_enc_vld,
   output logic                       o_dsr_enc_rdy,
   output logic [INSTR_W-1:0]         o_dsr_instr,
   output logic [INSTR_W-1:0]         o_dsr_imm,
   output logic                       o_dsr_imm_vld,
   output logic                       o_dsr_vld,
   input  logic                       i_dsr_rdy,
   output logic [$clog2(DEPTH+1)-1:0] o_dsr_cnt
);

   localparam int BEATS = INSTR_W / LANE_W;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int SW    = (LANE_W < INSTR_W) ? INSTR_W - LANE_W : 1;

   dsr_state_t         r_state;
   dsr_state_t         w_state_nxt;
   logic [BW-1:0]      r_beat;
   logic [SW-1:0]      r_shift;
   logic [INSTR_W-1:0] r_stage;
   logic [INSTR_W-1:0] w_word;
   logic               w_acc;
   logic               w_done;
   logic               w_push;
   logic               w_stage_ld;
   dsr_entry_t         w_entry;
   dsr_entry_t         w_head;
   logic [CW-1:0]      w_cnt;

   if (LANE_W < INSTR_W) begin : g_part
      assign w_word = {r_shift, i_dsr_enc};
   end else begin : g_full
      assign w_word = INSTR_W'(i_dsr_enc);
   end

   assign o_dsr_enc_rdy = (w_cnt < CW'(DEPTH));
   assign w_acc  = i_dsr_enc_vld && o_dsr_enc_rdy && !i_dsr_flush;
   assign w_done = w_acc && (r_beat == BW'(BEATS - 1));

   // Beat counter and MSB-first shift register for the current word.
   always_ff @(posedge i_dsr_gck or negedge i_dsr_rst_n) begin
      if (!i_dsr_rst_n) begin
         r_beat  <= '0;
         r_shift <= '0;
      end else if (i_dsr_flush) begin
         r_beat  <= '0;
         r_shift <= '0;
      end else if (w_acc) begin
         r_beat  <= w_done ? '0 : r_beat + BW'(1);
         r_shift <= w_word[SW-1:0];
      end
   end

   // State and staged instruction awaiting its immediate.
   always_ff @(posedge i_dsr_gck or negedge i_dsr_rst_n) begin
      if (!i_dsr_rst_n) begin
         r_state <= ST_INSTR;
         r_stage <= '0;
      end else if (i_dsr_flush) begin
         r_state <= ST_INSTR;
         r_stage <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_stage_ld) r_stage <= w_word;
      end
   end

   // Pair instructions with immediates and decide when to push.
   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_stage_ld  = 1'b0;
      w_entry     = '0;
      if (w_done) begin
         unique case (r_state)
            ST_INSTR: begin
               if (enc_has_imm(w_word)) begin
                  w_stage_ld  = 1'b1;
                  w_state_nxt = ST_IMM;
               end else begin
                  w_push        = 1'b1;
                  w_entry.instr = w_word;
               end
            end
            ST_IMM: begin
               w_push          = 1'b1;
               w_entry.instr   = r_stage;
               w_entry.imm     = w_word;
               w_entry.imm_vld = 1'b1;
               w_state_nxt     = ST_INSTR;
            end
            default: ;
         endcase
      end
   end

   idli_fifo_m #(
      .WIDTH ($bits(dsr_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_gck   (i_dsr_gck),
      .i_rst_n (i_dsr_rst_n),
      .i_flush (i_dsr_flush),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (i_dsr_rdy),
      .o_head  (w_head),
      .o_cnt   (w_cnt)
   );

   assign o_dsr_cnt     = w_cnt;
   assign o_dsr_vld     = (w_cnt != '0);
   assign o_dsr_instr   = o_dsr_vld ? w_head.instr : '0;
   assign o_dsr_imm     = o_dsr_vld ? w_head.imm : '0;
   assign o_dsr_imm_vld = o_dsr_vld && w_head.imm_vld;

endmodule

// File: tb/tb_idli_sqi_deser_m.sv
// Directed bench for idli_sqi_deser_m: nibble lanes with a
// 2-deep queue, and byte lanes with a 4-deep queue.
module tb_idli_sqi_deser_m;

   logic clk = 1'b0;
   logic rst_n;

   logic        flush4, ev4, rdy4, erdy4, vld4, imv4;
   logic [3:0]  enc4;
   logic [15:0] instr4, imm4;
   logic [1:0]  cnt4;

   logic        flush8, ev8, rdy8, erdy8, vld8, imv8;
   logic [7:0]  enc8;
   logic [15:0] instr8, imm8;
   logic [2:0]  cnt8;

   int checks   = 0;
   int failures = 0;
   logic over4  = 1'b0;

   always #5 clk = ~clk;

   idli_sqi_deser_m #(.LANE_W(4), .DEPTH(2)) u_d4 (
      .i_dsr_gck     (clk),
      .i_dsr_rst_n   (rst_n),
      .i_dsr_flush   (flush4),
      .i_dsr_enc     (enc4),
      .i_dsr_enc_vld (ev4),
      .o_dsr_enc_rdy (erdy4),
      .o_dsr_instr   (instr4),
      .o_dsr_imm     (imm4),
      .o_dsr_imm_vld (imv4),
      .o_dsr_vld     (vld4),
      .i_dsr_rdy     (rdy4),
      .o_dsr_cnt     (cnt4)
   );

   idli_sqi_deser_m #(.LANE_W(8), .DEPTH(4)) u_d8 (
      .i_dsr_gck     (clk),
      .i_dsr_rst_n   (rst_n),
      .i_dsr_flush   (flush8),
      .i_dsr_enc     (enc8),
      .i_dsr_enc_vld (ev8),
      .o_dsr_enc_rdy (erdy8),
      .o_dsr_instr   (instr8),
      .o_dsr_imm     (imm8),
      .o_dsr_imm_vld (imv8),
      .o_dsr_vld     (vld8),
      .i_dsr_rdy     (rdy8),
      .o_dsr_cnt     (cnt8)
   );

   always @(negedge clk) begin
      if (rst_n && cnt4 > 2'd2) over4 <= 1'b1;
   end

   typedef struct {
      logic [15:0] w0;
      logic [15:0] w1;
      bit          two;
      logic [15:0] ei;
      logic [15:0] em;
      bit          ev;
   } vec_t;

   vec_t vt [7];

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic beat4(input logic [3:0] b);
      int t;
      @(negedge clk);
      enc4 = b;
      ev4  = 1'b1;
      t    = 0;
      while (!erdy4 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         failures++;
         $display("FAIL beat4_timeout: got stalled expected accept");
      end
      @(posedge clk);
      #1 ev4 = 1'b0;
   endtask

   task automatic beat8(input logic [7:0] b);
      int t;
      @(negedge clk);
      enc8 = b;
      ev8  = 1'b1;
      t    = 0;
      while (!erdy8 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) begin
         checks++;
         failures++;
         $display("FAIL beat8_timeout: got stalled expected accept");
      end
      @(posedge clk);
      #1 ev8 = 1'b0;
   endtask

   task automatic word4(input logic [15:0] w);
      beat4(w[15:12]);
      beat4(w[11:8]);
      beat4(w[7:4]);
      beat4(w[3:0]);
   endtask

   task automatic word8(input logic [15:0] w);
      beat8(w[15:8]);
      beat8(w[7:0]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{16'hC241, 16'h0000, 1'b0, 16'hC241, 16'h0000, 1'b0};
      vt[1] = '{16'hC247, 16'h1234, 1'b1, 16'hC247, 16'h1234, 1'b1};
      vt[2] = '{16'h0007, 16'h0000, 1'b0, 16'h0007, 16'h0000, 1'b0};
      vt[3] = '{16'h0107, 16'hBEEF, 1'b1, 16'h0107, 16'hBEEF, 1'b1};
      vt[4] = '{16'hB8A7, 16'h0000, 1'b0, 16'hB8A7, 16'h0000, 1'b0};
      vt[5] = '{16'h5907, 16'h0000, 1'b0, 16'h5907, 16'h0000, 1'b0};
      vt[6] = '{16'h5107, 16'h00FF, 1'b1, 16'h5107, 16'h00FF, 1'b1};

      rst_n  = 1'b0;
      flush4 = 1'b0; ev4 = 1'b0; rdy4 = 1'b1; enc4 = '0;
      flush8 = 1'b0; ev8 = 1'b0; rdy8 = 1'b1; enc8 = '0;
      repeat (2) @(negedge clk);
      chk("rst_vld", vld4, 0);
      chk("rst_instr", instr4, 0);
      chk("rst_imm", imm4, 0);
      chk("rst_imv", imv4, 0);
      chk("rst_erdy", erdy4, 1);
      chk("rst_cnt", cnt4, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_vld", vld4, 0);

      for (int i = 0; i < 7; i++) begin
         word4(vt[i].w0);
         if (vt[i].two) begin
            @(negedge clk);
            chk($sformatf("v%0d_early", i), vld4, 0);
            word4(vt[i].w1);
         end
         @(negedge clk);
         chk($sformatf("v%0d_vld", i), vld4, 1);
         chk($sformatf("v%0d_instr", i), instr4, vt[i].ei);
         chk($sformatf("v%0d_imm", i), imm4, vt[i].em);
         chk($sformatf("v%0d_imv", i), imv4, vt[i].ev);
         @(negedge clk);
         chk($sformatf("v%0d_popped", i), vld4, 0);
      end

      rdy4 = 1'b0;
      word4(16'h1111);
      word4(16'h2222);
      @(negedge clk);
      chk("full_cnt", cnt4, 2);
      chk("full_erdy", erdy4, 0);
      fork
         word4(16'h3333);
         begin
            repeat (3) @(negedge clk);
            chk("stall_cnt", cnt4, 2);
            chk("stall_erdy", erdy4, 0);
            chk("pop1", instr4, 16'h1111);
            rdy4 = 1'b1;
            @(posedge clk);
            #1 rdy4 = 1'b0;
            @(negedge clk);
            chk("pop2", instr4, 16'h2222);
            rdy4 = 1'b1;
            @(posedge clk);
            #1 rdy4 = 1'b0;
         end
      join
      begin
         int t;
         t = 0;
         @(negedge clk);
         while (!vld4 && t < 20) begin
            @(negedge clk);
            t++;
         end
      end
      chk("pop3_vld", vld4, 1);
      chk("pop3", instr4, 16'h3333);
      chk("cnt_max", over4, 0);
      rdy4 = 1'b1;
      @(negedge clk);
      chk("drain", vld4, 0);

      rdy4 = 1'b0;
      word4(16'h1111);
      beat4(4'hC);
      beat4(4'h2);
      @(negedge clk);
      chk("pre_flush_cnt", cnt4, 1);
      flush4 = 1'b1;
      enc4   = 4'h4;
      ev4    = 1'b1;
      rdy4   = 1'b1;
      @(posedge clk);
      #1;
      flush4 = 1'b0;
      ev4    = 1'b0;
      rdy4   = 1'b0;
      @(negedge clk);
      chk("flush_cnt", cnt4, 0);
      chk("flush_vld", vld4, 0);
      chk("flush_erdy", erdy4, 1);
      rdy4 = 1'b1;
      word4(16'h5001);
      @(negedge clk);
      chk("aflush_vld", vld4, 1);
      chk("aflush_instr", instr4, 16'h5001);
      chk("aflush_imv", imv4, 0);

      word8(16'hC247);
      @(negedge clk);
      chk("b8_early", vld8, 0);
      word8(16'h1234);
      @(negedge clk);
      chk("b8_vld", vld8, 1);
      chk("b8_instr", instr8, 16'hC247);
      chk("b8_imm", imm8, 16'h1234);
      chk("b8_imv", imv8, 1);
      @(negedge clk);
      chk("b8_popped", vld8, 0);

      rdy8 = 1'b0;
      word8(16'h0001);
      beat8(8'hC2);
      beat8(8'h47);
      beat8(8'h12);
      @(negedge clk);
      chk("b8_pre_rst_cnt", cnt8, 1);
      rst_n = 1'b0;
      #1;
      chk("b8_rst_vld", vld8, 0);
      chk("b8_rst_instr", instr8, 0);
      chk("b8_rst_imm", imm8, 0);
      chk("b8_rst_imv", imv8, 0);
      chk("b8_rst_cnt", cnt8, 0);
      chk("b8_rst_erdy", erdy8, 1);
      @(negedge clk);
      rst_n = 1'b1;
      rdy8  = 1'b1;
      word8(16'h5501);
      @(negedge clk);
      chk("b8_after_vld", vld8, 1);
      chk("b8_after_instr", instr8, 16'h5501);
      chk("b8_after_imv", imv8, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
